// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings,
// default latencies and the busy-counter width helper.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MADD  = 4'd9;
  localparam logic [3:0] MD_MADDU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int cnt_width(input int mult_cycles, input int div_cycles);
    int max_cycles;
    max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for a multiply/divide start op.
// MDU_MADD_EN adds the MADD/MADDU accumulate forms.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  logic signed [63:0] w_rs_sx;
  logic signed [63:0] w_rt_sx;
  logic [63:0]        w_rs_zx;
  logic [63:0]        w_rt_zx;
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic signed [31:0] w_rs_s;
  logic signed [31:0] w_rt_s;
  logic signed [31:0] w_quot_s;
  logic signed [31:0] w_rem_s;
  logic               w_div_ovf;

  assign w_rs_sx  = {{32{rs_val[31]}}, rs_val};
  assign w_rt_sx  = {{32{rt_val[31]}}, rt_val};
  assign w_rs_zx  = {32'd0, rs_val};
  assign w_rt_zx  = {32'd0, rt_val};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = w_rs_zx * w_rt_zx;

  assign w_rs_s    = rs_val;
  assign w_rt_s    = rt_val;
  assign w_quot_s  = w_rs_s / w_rt_s;
  assign w_rem_s   = w_rs_s % w_rt_s;
  // The only signed quotient that does not fit in 32 bits.
  assign w_div_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  always_comb begin
    res_hi    = hi;
    res_lo    = lo;
    res_valid = 1'b0;
    case (md_op)
      MD_MULT: begin
        {res_hi, res_lo} = w_prod_s;
        res_valid        = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = w_prod_u;
        res_valid        = 1'b1;
      end
      MD_DIV: begin
        if (rt_val != 32'd0) begin
          res_valid = 1'b1;
          if (w_div_ovf) begin
            res_hi = 32'd0;
            res_lo = 32'h8000_0000;
          end else begin
            res_hi = w_rem_s;
            res_lo = w_quot_s;
          end
        end
      end
      MD_DIVU: begin
        if (rt_val != 32'd0) begin
          res_hi    = rs_val % rt_val;
          res_lo    = rs_val / rt_val;
          res_valid = 1'b1;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {res_hi, res_lo} = {hi, lo} + w_prod_s;
        res_valid        = 1'b1;
      end
      MD_MADDU: begin
        {res_hi, res_lo} = {hi, lo} + w_prod_u;
        res_valid        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency busy window, HI/LO registers.
// Define MDU_MADD_EN to accept MADD/MADDU as start ops.
//   state   | meaning
//   IDLE    | no op in flight; accepts starts and mthi/mtlo
//   BUSY    | counting down; pending result commits when cnt reaches 1
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  md_op,
  input  logic        md_start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_pend_valid;

  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_valid;
  logic        w_is_mul;
  logic        w_is_div;

  mdu_calc u_calc (
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi        (r_hi),
    .lo        (r_lo),
    .res_hi    (w_res_hi),
    .res_lo    (w_res_lo),
    .res_valid (w_res_valid)
  );

`ifdef MDU_MADD_EN
  assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                    (md_op == MD_MADD) || (md_op == MD_MADDU);
`else
  assign w_is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
`endif
  assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);

  // HI/LO cannot change while BUSY, so start-time HI/LO equals commit-time HI/LO for MADD.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_hi         <= 32'd0;
      r_lo         <= 32'd0;
      r_pend_hi    <= 32'd0;
      r_pend_lo    <= 32'd0;
      r_pend_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (md_start && (w_is_mul || w_is_div)) begin
            r_pend_hi    <= w_res_hi;
            r_pend_lo    <= w_res_lo;
            r_pend_valid <= w_res_valid;
            r_cnt        <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            r_state      <= ST_BUSY;
          end else if (md_op == MD_MTHI) begin
            r_hi <= rs_val;
          end else if (md_op == MD_MTLO) begin
            r_lo <= rs_val;
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            if (r_pend_valid) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_pend_valid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign md_busy  = (r_state == ST_BUSY);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_rdata = (md_op == MD_MFHI) ? r_hi :
                    (md_op == MD_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against a longint arithmetic model.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int N_MULT = 5;
  localparam int N_DIV  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  md_op;
  logic        md_start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .md_op    (md_op),
    .md_start (md_start),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_busy  (md_busy),
    .hi       (hi),
    .lo       (lo),
    .md_rdata (md_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] op);
    if (op == MD_MULT || op == MD_MULTU) return N_MULT;
    if (op == MD_DIV || op == MD_DIVU) return N_DIV;
`ifdef MDU_MADD_EN
    if (op == MD_MADD || op == MD_MADDU) return N_MULT;
`endif
    return 0;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MULTU: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_DIV: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      MD_DIVU: if (b != 0) begin
        q = longint'(ua / ub); r = longint'(ua % ub);
        m_lo = q[31:0]; m_hi = r[31:0];
      end
`ifdef MDU_MADD_EN
      MD_MADD:  begin p = {m_hi, m_lo} + 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      MD_MADDU: begin p = {m_hi, m_lo} + 64'(ua * ub); m_hi = p[63:32]; m_lo = p[31:0]; end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    md_op = op; rs_val = a; rt_val = b; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = MD_NONE;
    n = 0;
    while (md_busy === 1'b1 && n < 60) begin
      n++;
      step();
    end
    model(op, a, b);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles(op)));
    chk({tag, "_hi"}, hi, m_hi);
    chk({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    logic [3:0]  ops[6];
    logic [31:0] old_hi;
    int n;
    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU};

    reset_n = 1'b0; md_op = MD_NONE; md_start = 1'b0; rs_val = '0; rt_val = '0;
    step(); step();
    reset_n = 1'b1;
    m_hi = 0; m_lo = 0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(md_busy), 32'd0);

    run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFE);

    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", hi, 32'd1);
    md_op = MD_MFHI; #1;
    chk("mfhi_rdata", md_rdata, 32'd1);
    md_op = MD_MFLO; #1;
    chk("mflo_rdata", md_rdata, 32'hFFFF_FFFE);
    md_op = MD_NONE; #1;
    chk("none_rdata", md_rdata, 32'd0);

    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op("divu_by0", MD_DIVU, 32'd7, 32'd0);
    chk("divu_by0_hi_const", hi, 32'hFFFF_FFFF);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", lo, 32'h8000_0000);
    chk("div_ovf_hi_const", hi, 32'd0);

    md_op = MD_MTHI; rs_val = 32'h1234;
    step();
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(md_busy), 32'd0);
    md_op = MD_MTLO; rs_val = 32'h5678;
    step();
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_busy", 32'(md_busy), 32'd0);
    md_op = MD_NONE;
    m_hi = 32'h1234; m_lo = 32'h5678;

    // Illegal start, mthi and mfhi while busy.
    old_hi = m_hi;
    md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd4; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = MD_NONE;
    n = 0;
    while (md_busy === 1'b1 && n < 60) begin
      n++;
      if (n == 2) begin
        md_op = MD_DIV; md_start = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
      end else if (n == 3) begin
        md_op = MD_MTHI; md_start = 1'b0; rs_val = 32'hDEAD;
      end else if (n == 4) begin
        md_op = MD_MFHI; md_start = 1'b0; #1;
        chk("mfhi_while_busy", md_rdata, old_hi);
      end else begin
        md_op = MD_NONE; md_start = 1'b0;
      end
      step();
    end
    md_op = MD_NONE; md_start = 1'b0;
    model(MD_MULT, 32'd3, 32'd4);
    chk("busy_ignore_cycles", 32'(n), 32'(N_MULT));
    chk("busy_ignore_hi", hi, m_hi);
    chk("busy_ignore_lo", lo, m_lo);
    step(); step();
    chk("busy_ignore_no_restart", 32'(md_busy), 32'd0);

    md_op = 4'hF; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = MD_NONE;
    chk("bad_op_busy", 32'(md_busy), 32'd0);
    chk("bad_op_lo", lo, m_lo);

    // Reset during a divide: no commit afterwards.
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7; md_start = 1'b1;
    step();
    md_start = 1'b0; md_op = MD_NONE;
    step(); step(); step();
    chk("pre_abort_busy", 32'(md_busy), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", 32'(md_busy), 32'd0);
    repeat (12) step();
    chk("abort_no_commit_lo", lo, 32'd0);
    chk("abort_no_commit_busy", 32'(md_busy), 32'd0);
    m_hi = 0; m_lo = 0;

    md_op = MD_MTLO; rs_val = 32'hFFFF_FFFF;
    step();
    md_op = MD_NONE;
    m_lo = 32'hFFFF_FFFF;
    run_op("maddu", MD_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    chk("maddu_hi_const", hi, 32'd1);
    chk("maddu_lo_const", lo, 32'd0);
`else
    chk("maddu_hi_const", hi, 32'd0);
    chk("maddu_lo_const", lo, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [3:0]  op;
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) a = -a;
      run_op($sformatf("rand%0d", i), op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
